// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Covers the FSM state encoding, the MEM-stage load result-source code and the default timeout.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        D_REQ,
        D_WAIT,
        I_REQ,
        I_WAIT
    } arb_state_t;

    localparam logic [1:0]  RESULT_SRC_LOAD = 2'b01;
    localparam int unsigned ARB_MAX_WAIT    = 255;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Saturating wait counter for the response phase of a bus transaction.
// It asserts 'expired' once MAX_WAIT cycles have been counted.
module arb_timeout_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = ARB_MAX_WAIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_W'(MAX_WAIT))) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (cnt == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory bus between IF fetches and MEM loads/stores.
// stall_pipe holds the pipeline until every access needed in this pipeline cycle has completed.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = ARB_MAX_WAIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [DATA_W-1:0] if_rdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stall_pipe,
    output logic              bus_err
);

    arb_state_t state;
    logic       if_served;
    logic       mem_served;
    logic       expired;
    logic       in_req;
    logic       in_wait;
    logic       accept;
    logic       done_now;
    logic       timeout_now;
    logic       if_done_now;
    logic       mem_done_now;

    // A response cycle completes on rvalid or, failing that, on counter expiry.
    assign in_req       = (state == D_REQ) || (state == I_REQ);
    assign in_wait      = (state == D_WAIT) || (state == I_WAIT);
    assign accept       = in_req && bus_ready;
    assign done_now     = in_wait && (bus_rvalid || expired);
    assign timeout_now  = in_wait && !bus_rvalid && expired;
    assign mem_done_now = mem_served || ((state == D_WAIT) && done_now);
    assign if_done_now  = if_served || ((state == I_WAIT) && done_now);
    assign stall_pipe   = (if_req && !if_done_now) || (mem_req && !mem_done_now);

    arb_timeout_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .en      (in_wait),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            if_served  <= 1'b0;
            mem_served <= 1'b0;
            bus_valid  <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            bus_err    <= 1'b0;
        end else begin
            bus_err <= timeout_now;

            // Served flags live only while the pipeline is frozen on this cycle's requests.
            if (!stall_pipe) begin
                if_served  <= 1'b0;
                mem_served <= 1'b0;
            end else begin
                if ((state == D_WAIT) && done_now) mem_served <= 1'b1;
                if ((state == I_WAIT) && done_now) if_served  <= 1'b1;
            end

            case (state)
                IDLE: begin
                    // Data access belongs to the older instruction, so it goes first.
                    if (mem_req && !mem_served) begin
                        state     <= D_REQ;
                        bus_valid <= 1'b1;
                        bus_we    <= mem_we;
                        bus_addr  <= mem_addr;
                        bus_wdata <= mem_wdata;
                    end else if (if_req && !if_served) begin
                        state     <= I_REQ;
                        bus_valid <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_addr  <= if_addr;
                        bus_wdata <= '0;
                    end
                end
                D_REQ: begin
                    if (bus_ready) begin
                        state     <= D_WAIT;
                        bus_valid <= 1'b0;
                    end
                end
                I_REQ: begin
                    if (bus_ready) begin
                        state     <= I_WAIT;
                        bus_valid <= 1'b0;
                    end
                end
                D_WAIT: begin
                    if (done_now) begin
                        state <= IDLE;
                        if (!bus_we) mem_rdata <= bus_rvalid ? bus_rdata : '0;
                    end
                end
                I_WAIT: begin
                    if (done_now) begin
                        state    <= IDLE;
                        if_rdata <= bus_rvalid ? bus_rdata : '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized request groups.
// Expected bus activity, stall timing and read data come from a per-access cycle-budget model.
module tb_mem_port_arbiter;

    localparam int unsigned MAXW = 4;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic [31:0] if_rdata;
    logic [31:0] mem_rdata;
    logic        stall_pipe;
    logic        bus_err;

    int          checks = 0;
    int          errors = 0;
    logic        exp_err;
    logic [31:0] exp_if;
    logic [31:0] exp_mem;

    mem_port_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (MAXW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .if_rdata   (if_rdata),
        .mem_rdata  (mem_rdata),
        .stall_pipe (stall_pipe),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive bus inputs, sample at the falling edge, return just after the rising edge.
    task automatic do_cycle(input logic ready, input logic rvalid, input logic [31:0] rdata,
                            input logic exp_valid, input logic [31:0] exp_addr, input logic exp_we,
                            input logic [31:0] exp_wdata, input logic exp_stall, input logic err_next);
        bus_ready  = ready;
        bus_rvalid = rvalid;
        bus_rdata  = rdata;
        @(negedge clk);
        chk1("bus_valid", bus_valid, exp_valid);
        if (exp_valid) begin
            chk32("bus_addr", bus_addr, exp_addr);
            chk1("bus_we", bus_we, exp_we);
            if (exp_we) chk32("bus_wdata", bus_wdata, exp_wdata);
        end
        chk1("stall_pipe", stall_pipe, exp_stall);
        chk1("bus_err", bus_err, exp_err);
        @(posedge clk);
        #1;
        exp_err = err_next;
    endtask

    // One pipeline cycle of requests. Each access costs 1 idle + (r+1) request + (d+1) response
    // cycles; d >= MAXW means no rvalid, ending after MAXW+1 response cycles with rdata 0.
    task automatic run_group(input logic mreq, input logic we, input logic [31:0] maddr,
                             input logic [31:0] wdata, input logic ireq, input logic [31:0] iaddr,
                             input int r_d, input int d_d, input int r_i, input int d_i,
                             input logic [31:0] rd_fix);
        mem_req   = mreq;
        mem_we    = we;
        mem_addr  = maddr;
        mem_wdata = wdata;
        if_req    = ireq;
        if_addr   = iaddr;
        if (!mreq && !ireq) begin
            do_cycle(1'($urandom), 1'($urandom), $urandom, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
            return;
        end
        for (int a = 0; a < 2; a++) begin
            logic        is_data;
            logic        last;
            logic        w;
            logic        tmo;
            logic        fin;
            logic [31:0] addr;
            logic [31:0] rd;
            int          r;
            int          d;
            int          nw;
            is_data = (a == 0);
            if (is_data ? !mreq : !ireq) continue;
            last = !is_data || !ireq;
            addr = is_data ? maddr : iaddr;
            w    = is_data && we;
            r    = is_data ? r_d : r_i;
            d    = is_data ? d_d : d_i;
            tmo  = (d >= int'(MAXW));
            nw   = tmo ? int'(MAXW) + 1 : d + 1;
            do_cycle(1'($urandom), 1'($urandom), $urandom, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
            for (int k = 0; k <= r; k++) begin
                do_cycle(1'(k == r), 1'($urandom), $urandom, 1'b1, addr, w, wdata, 1'b1, 1'b0);
            end
            for (int k = 0; k < nw; k++) begin
                fin = (k == nw - 1);
                rd  = (rd_fix != 32'h0) ? rd_fix : $urandom;
                do_cycle(1'($urandom), fin && !tmo, rd, 1'b0, 32'h0, 1'b0, 32'h0,
                         !(last && fin), fin && tmo);
                if (fin) begin
                    if (is_data && !we) exp_mem = tmo ? 32'h0 : rd;
                    if (!is_data)       exp_if  = tmo ? 32'h0 : rd;
                end
            end
        end
        chk32("if_rdata", if_rdata, exp_if);
        chk32("mem_rdata", mem_rdata, exp_mem);
    endtask

    initial begin
        reset      = 1'b1;
        if_req     = 1'b0;
        if_addr    = 32'h0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;
        exp_err    = 1'b0;
        exp_if     = 32'h0;
        exp_mem    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_bus_valid", bus_valid, 1'b0);
        chk1("rst_bus_we", bus_we, 1'b0);
        chk1("rst_bus_err", bus_err, 1'b0);
        chk32("rst_bus_addr", bus_addr, 32'h0);
        chk32("rst_mem_rdata", mem_rdata, 32'h0);
        reset = 1'b0;
        do_cycle(1'b1, 1'b1, 32'h1111_1111, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Single load, immediate ready and response.
        run_group(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 0, 0, 0, 0, 32'hDEAD_BEEF);

        // Reset while waiting for a load response, then a stray rvalid in IDLE.
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h100;
        do_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        do_cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b0);
        reset   = 1'b1;
        mem_req = 1'b0;
        #1;
        chk1("mid_rst_bus_valid", bus_valid, 1'b0);
        chk1("mid_rst_bus_we", bus_we, 1'b0);
        chk1("mid_rst_bus_err", bus_err, 1'b0);
        chk1("mid_rst_stall", stall_pipe, 1'b0);
        chk32("mid_rst_bus_addr", bus_addr, 32'h0);
        chk32("mid_rst_bus_wdata", bus_wdata, 32'h0);
        chk32("mid_rst_if_rdata", if_rdata, 32'h0);
        chk32("mid_rst_mem_rdata", mem_rdata, 32'h0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_if  = 32'h0;
        exp_mem = 32'h0;
        exp_err = 1'b0;
        do_cycle(1'b0, 1'b1, 32'hAAAA_5555, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk32("stray_rvalid_mem_rdata", mem_rdata, 32'h0);
        do_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Store and fetch in the same pipeline cycle: store goes first.
        run_group(1'b1, 1'b1, 32'h200, 32'h1234, 1'b1, 32'h8, 0, 0, 0, 0, 32'h0);

        // Store held in request phase for four not-ready cycles.
        run_group(1'b1, 1'b1, 32'h300, 32'hCAFE_F00D, 1'b0, 32'h0, 4, 1, 0, 0, 32'h0);

        // Back-to-back fetches.
        run_group(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 0, 0, 0, 0, 32'h0);
        run_group(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h4, 0, 0, 0, 0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            run_group(1'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom,
                      1'($urandom), $urandom & 32'hFFFF_FFFC,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), 32'h0);
        end

        // Load with a known value, then a load that never gets a response.
        run_group(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0, 0, 0, 0, 0, 32'h5A5A_0001);
        run_group(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 32'h0, 0, int'(MAXW), 0, 0, 32'h0);
        run_group(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 0, 0, 0, 32'h0);
        run_group(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 0, 0, 0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

endmodule
